signed_minmax_tracker: RTL and testbench

SIGNED_MINMAX_TRACKER -- requirements
Module: signed_minmax_tracker

---
 rtl/minmax_pkg.sv | 14 +
 rtl/mode_comparator.sv | 33 +++
 rtl/signed_minmax_tracker.sv | 137 +++++++++++++
 tb/tb_signed_minmax_tracker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types for the signed/unsigned running min/max tracker.
// Holds the tracker FSM states and the compare-mode encoding.
package minmax_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mode_comparator.sv
// Combinational magnitude compare of a against b, either as unsigned
// values or as two's-complement values depending on mode.
module mode_comparator
  import minmax_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    eq = (a == b);
    if (mode == MODE_SIGNED) begin
      gt = (a_s > b_s);
      lt = (a_s < b_s);
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
  end

endmodule

// File: rtl/signed_minmax_tracker.sv
// Running min/max tracker with per-sample compare against the previous
// sample; the compare mode is latched by the first sample after reset/clear.
module signed_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] count,
  output logic             have_data,
  output logic             cmp_valid,
  output logic             cmp_gt,
  output logic             cmp_eq,
  output logic             cmp_lt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q;
  state_e             state_nxt;
  logic               mode_q;
  logic [WIDTH-1:0]   prev_q;
  logic [CNT_W-1:0]   count_inc;
  logic               accept_first;
  logic               accept_track;

  logic min_gt, min_eq, min_lt;
  logic max_gt, max_eq, max_lt;
  logic prv_gt, prv_eq, prv_lt;
  logic cmp_unused;

  assign count_inc  = count + CNT_ONE;
  // Only the strict sides of the min/max compares drive updates; ties keep the earliest index.
  assign cmp_unused = &{1'b0, min_gt, min_eq, max_eq, max_lt};

  mode_comparator #(.WIDTH(WIDTH)) u_cmp_min (
    .a(in_data), .b(min_val), .mode(mode_q), .gt(min_gt), .eq(min_eq), .lt(min_lt)
  );

  mode_comparator #(.WIDTH(WIDTH)) u_cmp_max (
    .a(in_data), .b(max_val), .mode(mode_q), .gt(max_gt), .eq(max_eq), .lt(max_lt)
  );

  mode_comparator #(.WIDTH(WIDTH)) u_cmp_prev (
    .a(in_data), .b(prev_q), .mode(mode_q), .gt(prv_gt), .eq(prv_eq), .lt(prv_lt)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    accept_first = 1'b0;
    accept_track = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          accept_first = 1'b1;
          state_nxt    = (CNT_ONE == CNT_MAX) ? FULL : TRACK;
        end
      end
      TRACK: begin
        if (in_valid) begin
          accept_track = 1'b1;
          if (count_inc == CNT_MAX) begin
            state_nxt = FULL;
          end
        end
      end
      FULL:    state_nxt = FULL;
      default: state_nxt = EMPTY;
    endcase
  end

  assign have_data = (state_q != EMPTY);
  assign full      = (state_q == FULL);

  // Registered result stage: everything below updates on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mode_q    <= MODE_UNSIGNED;
      prev_q    <= '0;
      min_val   <= '0;
      max_val   <= '0;
      min_idx   <= '0;
      max_idx   <= '0;
      count     <= '0;
      cmp_valid <= 1'b0;
      cmp_gt    <= 1'b0;
      cmp_eq    <= 1'b0;
      cmp_lt    <= 1'b0;
    end else begin
      cmp_valid <= accept_track;
      if (accept_first) begin
        mode_q  <= mode;
        prev_q  <= in_data;
        min_val <= in_data;
        max_val <= in_data;
        min_idx <= '0;
        max_idx <= '0;
        count   <= CNT_ONE;
      end else if (accept_track) begin
        if (min_lt) begin
          min_val <= in_data;
          min_idx <= count;
        end
        if (max_gt) begin
          max_val <= in_data;
          max_idx <= count;
        end
        cmp_gt <= prv_gt;
        cmp_eq <= prv_eq;
        cmp_lt <= prv_lt;
        prev_q <= in_data;
        count  <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Bench for signed_minmax_tracker: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the accepted samples.
module tb_signed_minmax_tracker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] min_val, max_val;
  logic [CNT_W-1:0] min_idx, max_idx, count;
  logic             have_data, cmp_valid, cmp_gt, cmp_eq, cmp_lt, full;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the list of accepted samples plus the latched mode.
  logic [7:0] mq[$];
  bit         m_mode;
  bit         e_cv, e_gt, e_eq, e_lt;

  signed_minmax_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .min_val(min_val), .max_val(max_val), .min_idx(min_idx), .max_idx(max_idx),
    .count(count), .have_data(have_data), .cmp_valid(cmp_valid),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .full(full)
  );

  always #5 clk = ~clk;

  function automatic int sval(logic [7:0] x, bit m);
    return m ? int'($signed(x)) : int'(x);
  endfunction

  function automatic int min_index();
    int bi = 0;
    for (int i = 1; i < mq.size(); i++)
      if (sval(mq[i], m_mode) < sval(mq[bi], m_mode)) bi = i;
    return bi;
  endfunction

  function automatic int max_index();
    int bi = 0;
    for (int i = 1; i < mq.size(); i++)
      if (sval(mq[i], m_mode) > sval(mq[bi], m_mode)) bi = i;
    return bi;
  endfunction

  function automatic logic [7:0] exp_min();
    return (mq.size() == 0) ? 8'h00 : mq[min_index()];
  endfunction

  function automatic logic [7:0] exp_max();
    return (mq.size() == 0) ? 8'h00 : mq[max_index()];
  endfunction

  task automatic model_step(bit rc, bit v, logic [7:0] d, bit md);
    e_cv = 1'b0;
    if (rc) begin
      mq.delete();
      m_mode = 1'b0;
      e_gt = 1'b0; e_eq = 1'b0; e_lt = 1'b0;
    end else if (v && mq.size() < 255) begin
      if (mq.size() == 0) begin
        m_mode = md;
      end else begin
        int a;
        int b;
        a = sval(d, m_mode);
        b = sval(mq[mq.size()-1], m_mode);
        e_cv = 1'b1;
        e_gt = (a > b); e_eq = (a == b); e_lt = (a < b);
      end
      mq.push_back(d);
    end
  endtask

  task automatic cyc(bit c, bit v, logic [7:0] d, bit md);
    clear = c; in_valid = v; in_data = d; mode = md;
    @(posedge clk);
    #1;
    model_step(c, v, d, md);
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({min_val, max_val, min_idx, max_idx, count} !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h/%h/%0d/%0d/%0d want all 0", min_val, max_val, min_idx, max_idx, count);
    end
    vectors++;
    if ({have_data, cmp_valid, cmp_gt, cmp_eq, cmp_lt, full} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000000", {have_data, cmp_valid, cmp_gt, cmp_eq, cmp_lt, full});
    end
  endtask

  task automatic test_signed_basic();
    do_reset();
    cyc(1'b0, 1'b1, 8'h80, 1'b1);
    cyc(1'b0, 1'b1, 8'h7F, 1'b1);
    vectors++;
    if ({min_val, min_idx, max_val, max_idx} !== {8'h80, 8'd0, 8'h7F, 8'd1}) begin
      miscompares++;
      $display("FAIL signed_minmax got %h/%0d %h/%0d want 80/0 7f/1", min_val, min_idx, max_val, max_idx);
    end
    vectors++;
    if ({cmp_valid, cmp_gt, cmp_eq, cmp_lt} !== 4'b1100) begin
      miscompares++;
      $display("FAIL signed_cmp got %b want 1100", {cmp_valid, cmp_gt, cmp_eq, cmp_lt});
    end
  endtask

  task automatic test_unsigned_basic();
    do_reset();
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    cyc(1'b0, 1'b1, 8'h7F, 1'b0);
    vectors++;
    if ({min_val, min_idx, max_val, max_idx} !== {8'h7F, 8'd1, 8'h80, 8'd0}) begin
      miscompares++;
      $display("FAIL unsigned_minmax got %h/%0d %h/%0d want 7f/1 80/0", min_val, min_idx, max_val, max_idx);
    end
    vectors++;
    if ({cmp_valid, cmp_gt, cmp_eq, cmp_lt} !== 4'b1001) begin
      miscompares++;
      $display("FAIL unsigned_cmp got %b want 1001", {cmp_valid, cmp_gt, cmp_eq, cmp_lt});
    end
  endtask

  task automatic test_tie();
    logic [7:0] seq [5];
    seq = '{8'h6F, 8'h58, 8'hAF, 8'hFA, 8'hAF};
    do_reset();
    foreach (seq[i]) cyc(1'b0, 1'b1, seq[i], 1'b1);
    vectors++;
    if ({min_val, min_idx, max_val, max_idx, count} !== {8'hAF, 8'd2, 8'h6F, 8'd0, 8'd5}) begin
      miscompares++;
      $display("FAIL tie got min %h/%0d max %h/%0d cnt %0d want af/2 6f/0 5", min_val, min_idx, max_val, max_idx, count);
    end
    vectors++;
    if ({cmp_valid, cmp_lt} !== 2'b11) begin
      miscompares++;
      $display("FAIL tie_cmp got valid=%b lt=%b want 1 1", cmp_valid, cmp_lt);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    vectors++;
    if ({cmp_valid, cmp_gt, cmp_eq, cmp_lt} !== 4'b0001) begin
      miscompares++;
      $display("FAIL idle_hold got %b want 0001", {cmp_valid, cmp_gt, cmp_eq, cmp_lt});
    end
  endtask

  task automatic test_full();
    logic [7:0] mx;
    do_reset();
    for (int i = 0; i < 255; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 8'h50)), 1'b1);
    vectors++;
    if ({full, count} !== {1'b1, 8'd255}) begin
      miscompares++;
      $display("FAIL full_reach got full=%b count=%0d want 1 255", full, count);
    end
    mx = exp_max();
    cyc(1'b0, 1'b1, 8'h7F, 1'b1);
    vectors++;
    if ({max_val, max_idx, count, cmp_valid} !== {mx, 8'(max_index()), 8'd255, 1'b0}) begin
      miscompares++;
      $display("FAIL full_ignore got max %h/%0d cnt %0d cv %b want %h/%0d 255 0", max_val, max_idx, count, cmp_valid, mx, max_index());
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    vectors++;
    if ({min_val, max_val, min_idx, max_idx, count, have_data, cmp_valid, cmp_gt, cmp_eq, cmp_lt, full} !== 46'h0) begin
      miscompares++;
      $display("FAIL full_clear got %h %h %0d %0d %0d %b%b%b%b%b%b want all 0", min_val, max_val, min_idx, max_idx, count,
               have_data, cmp_valid, cmp_gt, cmp_eq, cmp_lt, full);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    cyc(1'b1, 1'b1, 8'h05, 1'b0);
    vectors++;
    if ({have_data, count} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL clear_wins got have_data=%b count=%0d want 0 0", have_data, count);
    end
    cyc(1'b0, 1'b1, 8'h09, 1'b0);
    vectors++;
    if ({min_val, max_val, count, cmp_valid} !== {8'h09, 8'h09, 8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL after_clear got %h %h %0d %b want 09 09 1 0", min_val, max_val, count, cmp_valid);
    end
  endtask

  task automatic test_mode_toggle();
    do_reset();
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    vectors++;
    if ({min_val, min_idx, max_val, cmp_lt} !== {8'h80, 8'd1, 8'h01, 1'b1}) begin
      miscompares++;
      $display("FAIL mode_latch got min %h/%0d max %h lt %b want 80/1 01 1", min_val, min_idx, max_val, cmp_lt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b0, 1'b1, 8'h40, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    cyc(1'b0, 1'b1, 8'hF0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b1, 8'h10, 1'b0);
    vectors++;
    if ({min_idx, max_idx, count, cmp_valid, min_val} !== {8'd0, 8'd0, 8'd1, 1'b0, 8'h10}) begin
      miscompares++;
      $display("FAIL restart got idx %0d/%0d cnt %0d cv %b min %h want 0/0 1 0 10", min_idx, max_idx, count, cmp_valid, min_val);
    end
    cyc(1'b0, 1'b1, 8'h20, 1'b0);
    vectors++;
    if ({max_val, max_idx, cmp_valid, cmp_gt} !== {8'h20, 8'd1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b got max %h/%0d cv %b gt %b want 20/1 1 1", max_val, max_idx, cmp_valid, cmp_gt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit c, v, md;
      c  = ($urandom_range(0, 99) < 3);
      v  = ($urandom_range(0, 99) < 75);
      md = 1'($urandom);
      cyc(c, v, 8'($urandom), md);
      vectors++;
      if ({min_val, max_val} !== {exp_min(), exp_max()}) begin
        miscompares++;
        $display("FAIL rnd_val[%0d] got %h/%h want %h/%h", n, min_val, max_val, exp_min(), exp_max());
      end
      vectors++;
      if ({min_idx, max_idx, count} !== {8'(min_index()), 8'(max_index()), 8'(mq.size())}) begin
        miscompares++;
        $display("FAIL rnd_idx[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", n, min_idx, max_idx, count,
                 min_index(), max_index(), mq.size());
      end
      vectors++;
      if ({have_data, full, cmp_valid, cmp_gt, cmp_eq, cmp_lt} !==
          {mq.size() != 0, mq.size() == 255, e_cv, e_gt, e_eq, e_lt}) begin
        miscompares++;
        $display("FAIL rnd_flags[%0d] got %b want %b", n, {have_data, full, cmp_valid, cmp_gt, cmp_eq, cmp_lt},
                 {mq.size() != 0, mq.size() == 255, e_cv, e_gt, e_eq, e_lt});
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_unsigned_basic();
    test_tie();
    test_full();
    test_clear_collision();
    test_mode_toggle();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
